// File: rtl/round_key_manager.sv
// Round-key manager: expands a 128-bit master key into ROUNDS 64-bit
// round keys (one round per clock) and serves registered table reads.
module round_key_manager #(
  parameter int ROUNDS = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_valid,
  input  logic [127:0] key,
  output logic         key_ready,
  output logic         busy,
  output logic         keys_ready,
  input  logic         rd_en,
  input  logic [4:0]   rd_idx,
  output logic         rd_valid,
  output logic [63:0]  rd_key,
  output logic         rd_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    READY  = 2'd2
  } state_t;

  // Table count as a 6-bit value so rd_idx can be range-checked for ROUNDS=32.
  localparam logic [5:0] ROUNDS_W = 6'(ROUNDS);
  // Counter value of the round that writes the final table entry.
  localparam logic [4:0] LAST_I   = 5'(ROUNDS - 2);

  state_t      state_r;
  state_t      next_state_s;
  logic [63:0] l_r;
  logic [63:0] k_r;
  logic [4:0]  i_r;
  logic [63:0] rk_mem_r [32];

  logic        key_ready_r;
  logic        busy_r;
  logic        keys_ready_r;
  logic        rd_valid_r;
  logic        rd_err_r;
  logic [63:0] rd_key_r;

  logic        accept_s;
  logic        last_round_s;
  logic        rd_ok_s;
  logic [63:0] l_next_s;
  logic [63:0] k_next_s;

  function automatic logic [63:0] ror8(input logic [63:0] v);
    return {v[7:0], v[63:8]};
  endfunction

  function automatic logic [63:0] rol3(input logic [63:0] v);
    return {v[60:0], v[63:61]};
  endfunction

  assign key_ready  = key_ready_r;
  assign busy       = busy_r;
  assign keys_ready = keys_ready_r;
  assign rd_valid   = rd_valid_r;
  assign rd_err     = rd_err_r;
  assign rd_key     = rd_key_r;

  // Handshake, read qualification and one expansion round (carry beyond bit 63 drops).
  always_comb begin
    accept_s     = key_valid & key_ready_r;
    last_round_s = (i_r == LAST_I);
    rd_ok_s      = keys_ready_r & ({1'b0, rd_idx} < ROUNDS_W);
    l_next_s     = (k_r + ror8(l_r)) ^ {59'd0, i_r};
    k_next_s     = rol3(k_r) ^ l_next_s;
  end

  // Next-state decode; a key is only taken outside EXPAND.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) next_state_s = EXPAND;
        else          next_state_s = IDLE;
      end
      EXPAND: begin
        if (last_round_s) next_state_s = READY;
        else              next_state_s = EXPAND;
      end
      READY: begin
        if (accept_s) next_state_s = EXPAND;
        else          next_state_s = READY;
      end
      default: next_state_s = IDLE;
    endcase
  end

  // State register and status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      key_ready_r  <= 1'b1;
      busy_r       <= 1'b0;
      keys_ready_r <= 1'b0;
    end else begin
      state_r      <= next_state_s;
      key_ready_r  <= (next_state_s != EXPAND);
      busy_r       <= (next_state_s == EXPAND);
      keys_ready_r <= (next_state_s == READY);
    end
  end

  // Working registers: load the master key on acceptance, step once per EXPAND cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      l_r <= 64'd0;
      k_r <= 64'd0;
      i_r <= 5'd0;
    end else if (accept_s) begin
      l_r <= key[127:64];
      k_r <= key[63:0];
      i_r <= 5'd0;
    end else if (state_r == EXPAND) begin
      l_r <= l_next_s;
      k_r <= k_next_s;
      i_r <= i_r + 5'd1;
    end else begin
      l_r <= l_r;
      k_r <= k_r;
      i_r <= i_r;
    end
  end

  // Round-key table; deliberately not reset, keys_ready alone marks it valid.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      rk_mem_r[0] <= key[63:0];
    end else if (state_r == EXPAND) begin
      rk_mem_r[i_r + 5'd1] <= k_next_s;
    end
  end

  // Read port: the table read sees the pre-edge contents, so a read coinciding
  // with a new key acceptance returns the old table entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
      rd_key_r   <= 64'd0;
    end else if (rd_en && rd_ok_s) begin
      rd_valid_r <= 1'b1;
      rd_err_r   <= 1'b0;
      rd_key_r   <= rk_mem_r[rd_idx];
    end else if (rd_en) begin
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b1;
      rd_key_r   <= rd_key_r;
    end else begin
      rd_valid_r <= 1'b0;
      rd_err_r   <= 1'b0;
      rd_key_r   <= rd_key_r;
    end
  end

endmodule

// File: tb/tb_round_key_manager.sv
// Self-checking bench for round_key_manager: a default (32-round) instance
// and a 16-round instance, checked against a software key-schedule model.
module tb_round_key_manager;

  logic         clk;
  logic         rst_n;

  logic         key_valid, key_valid_b;
  logic [127:0] key, key_b;
  logic         key_ready, key_ready_b;
  logic         busy, busy_b;
  logic         keys_ready, keys_ready_b;
  logic         rd_en, rd_en_b;
  logic [4:0]   rd_idx, rd_idx_b;
  logic         rd_valid, rd_valid_b;
  logic [63:0]  rd_key, rd_key_b;
  logic         rd_err, rd_err_b;

  int           n_tests;
  int           n_fail;
  logic [63:0]  last_rd_a;
  logic [63:0]  last_rd_b;
  logic [127:0] cur_a;
  logic [127:0] k1, k3;
  int           cnt;

  round_key_manager dut_a (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key(key),
    .key_ready(key_ready), .busy(busy), .keys_ready(keys_ready),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_valid(rd_valid),
    .rd_key(rd_key), .rd_err(rd_err)
  );

  round_key_manager #(.ROUNDS(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_valid(key_valid_b), .key(key_b),
    .key_ready(key_ready_b), .busy(busy_b), .keys_ready(keys_ready_b),
    .rd_en(rd_en_b), .rd_idx(rd_idx_b), .rd_valid(rd_valid_b),
    .rd_key(rd_key_b), .rd_err(rd_err_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Round key number idx of master key mk, straight from the schedule rules.
  function automatic logic [63:0] model_rk(input logic [127:0] mk, input int idx);
    logic [63:0] l, k;
    l = mk[127:64];
    k = mk[63:0];
    for (int r = 0; r < idx; r++) begin
      l = (k + ((l >> 8) | (l << 56))) ^ 64'(r);
      k = ((k << 3) | (k >> 61)) ^ l;
    end
    return k;
  endfunction

  task automatic load_a(input logic [127:0] mk);
    @(negedge clk);
    key = mk;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    cur_a = mk;
  endtask

  task automatic wait_ready_a(output int c);
    c = 0;
    while (!keys_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
  endtask

  task automatic read_a(input logic [4:0] idx, input bit ok, input logic [63:0] exp);
    @(negedge clk);
    rd_en = 1'b1;
    rd_idx = idx;
    @(negedge clk);
    rd_en = 1'b0;
    if (ok) begin
      check_eq("a_rd_valid", rd_valid, 1'b1);
      check_eq("a_rd_err", rd_err, 1'b0);
      check_eq("a_rd_key", rd_key, exp);
      last_rd_a = exp;
    end else begin
      check_eq("a_err_valid", rd_valid, 1'b0);
      check_eq("a_err_pulse", rd_err, 1'b1);
      check_eq("a_err_key_hold", rd_key, last_rd_a);
    end
  endtask

  task automatic read_b(input logic [4:0] idx, input bit ok, input logic [63:0] exp);
    @(negedge clk);
    rd_en_b = 1'b1;
    rd_idx_b = idx;
    @(negedge clk);
    rd_en_b = 1'b0;
    if (ok) begin
      check_eq("b_rd_valid", rd_valid_b, 1'b1);
      check_eq("b_rd_key", rd_key_b, exp);
      last_rd_b = exp;
    end else begin
      check_eq("b_err_valid", rd_valid_b, 1'b0);
      check_eq("b_err_pulse", rd_err_b, 1'b1);
      check_eq("b_err_key_hold", rd_key_b, last_rd_b);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail = 0;
    last_rd_a = 64'd0;
    last_rd_b = 64'd0;
    cur_a = 128'd0;
    rst_n = 1'b0;
    key_valid = 1'b0; key = 128'd0; rd_en = 1'b0; rd_idx = 5'd0;
    key_valid_b = 1'b0; key_b = 128'd0; rd_en_b = 1'b0; rd_idx_b = 5'd0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_key_ready", key_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_keys_ready", keys_ready, 1'b0);
    check_eq("rst_rd_valid", rd_valid, 1'b0);
    check_eq("rst_rd_err", rd_err, 1'b0);
    check_eq("rst_rd_key", rd_key, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vector and expansion latency
    load_a(128'h0f0e0d0c0b0a0908_0706050403020100);
    check_eq("exp_busy", busy, 1'b1);
    check_eq("exp_key_ready", key_ready, 1'b0);
    wait_ready_a(cnt);
    check_eq("kat_latency", 64'(cnt), 64'd31);
    check_eq("kat_busy_done", busy, 1'b0);
    check_eq("kat_key_ready", key_ready, 1'b1);
    read_a(5'd0, 1'b1, 64'h0706050403020100);
    read_a(5'd1, 1'b1, 64'h37253b31171d0309);
    read_a(5'd31, 1'b1, model_rk(cur_a, 31));

    // Back-to-back burst of all 32 keys
    load_a({16{8'hab}});
    wait_ready_a(cnt);
    check_eq("abab_latency", 64'(cnt), 64'd31);
    for (int i = 0; i <= 32; i++) begin
      @(negedge clk);
      if (i > 0) begin
        check_eq("burst_valid", rd_valid, 1'b1);
        check_eq("burst_key", rd_key, model_rk(cur_a, i - 1));
      end
      if (i < 32) begin
        rd_en = 1'b1;
        rd_idx = 5'(i);
      end else begin
        rd_en = 1'b0;
      end
    end
    @(negedge clk);
    check_eq("burst_end_valid", rd_valid, 1'b0);
    last_rd_a = model_rk(cur_a, 31);

    // Random keys and random indices
    for (int t = 0; t < 3; t++) begin
      load_a({$urandom, $urandom, $urandom, $urandom});
      wait_ready_a(cnt);
      check_eq("rand_latency", 64'(cnt), 64'd31);
      for (int j = 0; j < 5; j++) begin
        logic [4:0] ix;
        ix = 5'($urandom_range(31, 0));
        read_a(ix, 1'b1, model_rk(cur_a, int'(ix)));
      end
    end

    // Read while busy is rejected
    load_a({$urandom, $urandom, $urandom, $urandom});
    repeat (3) @(negedge clk);
    read_a(5'd3, 1'b0, 64'd0);
    wait_ready_a(cnt);
    check_eq("busy_rd_keys_ready", keys_ready, 1'b1);

    // key_valid during EXPAND is ignored
    k1 = {$urandom, $urandom, $urandom, $urandom};
    load_a(k1);
    repeat (5) @(negedge clk);
    key = ~k1;
    key_valid = 1'b1;
    @(negedge clk);
    key_valid = 1'b0;
    wait_ready_a(cnt);
    check_eq("ignore_keys_ready", keys_ready, 1'b1);
    read_a(5'd0, 1'b1, model_rk(k1, 0));
    read_a(5'd10, 1'b1, model_rk(k1, 10));
    read_a(5'd31, 1'b1, model_rk(k1, 31));

    // 16-round instance: latency and out-of-range index
    @(negedge clk);
    key_b = cur_a;
    key_valid_b = 1'b1;
    @(negedge clk);
    key_valid_b = 1'b0;
    cnt = 0;
    while (!keys_ready_b && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("b_latency", 64'(cnt), 64'd15);
    read_b(5'd15, 1'b1, model_rk(key_b, 15));
    read_b(5'd31, 1'b0, 64'd0);
    read_b(5'd16, 1'b0, 64'd0);
    read_b(5'd0, 1'b1, model_rk(key_b, 0));

    // New key and read on the same READY edge
    k3 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    key = k3;
    key_valid = 1'b1;
    rd_en = 1'b1;
    rd_idx = 5'd5;
    @(negedge clk);
    key_valid = 1'b0;
    rd_en = 1'b0;
    cur_a = k3;
    check_eq("same_edge_valid", rd_valid, 1'b1);
    check_eq("same_edge_old_key", rd_key, model_rk(k1, 5));
    check_eq("same_edge_keys_ready", keys_ready, 1'b0);
    check_eq("same_edge_busy", busy, 1'b1);
    last_rd_a = model_rk(k1, 5);
    wait_ready_a(cnt);
    check_eq("same_edge_latency", 64'(cnt), 64'd31);
    read_a(5'd5, 1'b1, model_rk(k3, 5));
    read_a(5'd31, 1'b1, model_rk(k3, 31));

    // Reset in the middle of an expansion
    load_a({$urandom, $urandom, $urandom, $urandom});
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_keys_ready", keys_ready, 1'b0);
    check_eq("midrst_key_ready", key_ready, 1'b1);
    check_eq("midrst_rd_key", rd_key, 64'd0);
    check_eq("midrst_rd_valid", rd_valid, 1'b0);
    check_eq("midrst_rd_err", rd_err, 1'b0);
    last_rd_a = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    read_a(5'd0, 1'b0, 64'd0);
    @(negedge clk);
    check_eq("postrst_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/round_key_manager.md
ROUND_KEY_MANAGER -- requirements
Module: round_key_manager

Interface
REQ-001 SHALL have parameter ROUNDS, default 32, number of 64-bit round keys expanded and stored; legal range 2..32.
REQ-002 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port key_valid, input, 1, master key offered.
REQ-005 SHALL have port key, input, 128, master key: l0 = key[127:64], k0 = key[63:0].
REQ-006 SHALL have port key_ready, output, 1, block can accept a key this cycle.
REQ-007 SHALL have port busy, output, 1, expansion in progress.
REQ-008 SHALL have port keys_ready, output, 1, full round-key table is valid.
REQ-009 SHALL have port rd_en, input, 1, round-key read request.
REQ-010 SHALL have port rd_idx, input, 5, round-key index.
REQ-011 SHALL have port rd_valid, output, 1, one-cycle pulse: rd_key holds the requested key.
REQ-012 SHALL have port rd_key, output, 64, registered round key.
REQ-013 SHALL have port rd_err, output, 1, one-cycle pulse: read rejected.

Function
REQ-014 SHALL implement FSM states IDLE, EXPAND and READY.
REQ-015 SHALL drive key_ready=1 in IDLE and READY and key_ready=0 in EXPAND; key_valid during EXPAND is ignored.
REQ-016 SHALL accept a key on an edge where key_valid and key_ready are both 1, store rk[0]=k0 on that edge, load working registers (l0,k0), set counter i=0, clear keys_ready and enter EXPAND.
REQ-017 SHALL compute one round per EXPAND cycle: l' = (k + ROR(l,8)) mod 2^64 XOR zero-extended i; k' = ROL(k,3) XOR l'; rk[i+1]=k'; i increments by 1.
REQ-018 SHALL, on the edge that writes rk[ROUNDS-1], go to READY and set keys_ready=1; keys_ready is therefore high ROUNDS-1 cycles after the acceptance edge (31 cycles at default).
REQ-019 SHALL hold busy=1 exactly while in EXPAND.
REQ-020 SHALL serve a read with rd_en=1, keys_ready=1 and rd_idx<ROUNDS by registering rk[rd_idx] into rd_key and pulsing rd_valid on the next edge (1-cycle latency); back-to-back reads SHALL be sustained every cycle.
REQ-021 SHALL reject a read with keys_ready=0 or rd_idx>=ROUNDS by pulsing rd_err for one cycle, leaving rd_valid=0 and rd_key unchanged.
REQ-022 SHALL, when a read and a key acceptance occur on the same READY edge, serve the read from the old table and then start the new expansion.
REQ-023 SHALL hold rd_key stable between reads.
REQ-024 SHALL use modulo-2^64 addition with carries discarded, and 8-bit/3-bit rotations over exactly 64 bits.

Reset
REQ-025 SHALL, on rst_n=0 and independent of clk, force state IDLE, i=0, busy=0, keys_ready=0, rd_valid=0, rd_err=0 and rd_key=0; key_ready=1 after reset.
REQ-026 SHALL not reset the round-key table contents; keys_ready=0 alone marks it invalid.
REQ-027 SHALL abandon any expansion in progress when reset is asserted mid-EXPAND; after release, a new key is required before any read succeeds.

Verification
REQ-028 Key 0f0e0d0c0b0a0908_0706050403020100 -> keys_ready high 31 cycles after acceptance; read idx 0 -> 0706050403020100; read idx 1 -> 37253b31171d0309.
REQ-029 Key abab...ab -> each rd_key from consecutive reads idx 0..31 matches the bench's software model; rd_valid is high for 32 consecutive cycles.
REQ-030 rd_en while busy, and rd_idx=31 with ROUNDS=16 -> rd_err pulses, rd_valid=0, rd_key unchanged.
REQ-031 key_valid pulsed during EXPAND -> ignored; the table reflects only the first key.
REQ-032 rst_n dropped at cycle 10 of EXPAND -> outputs reach reset values immediately; a read after release -> rd_err.
REQ-033 New key and read idx 5 on the same READY edge -> rd_key = old rk[5], keys_ready falls, then rises 31 cycles later with the new table.
